cache_port_arbiter: RTL
=======================

Name: cache_port_arbiter

Overview:
- Two-requester round-robin arbiter in front of the cache controller's CPU-side interface (read/write/address/write-data in; read-data/done out).
- Lets two independent masters (e.g. instruction fetch and data port) share one controller.
- Owns one transaction at a time, holds the controller request lines until done, returns data and ack to the winner.
- Watchdog aborts a transaction the controller never completes.

Parameters:
ADDR_W, 32, address width
DATA_W, 512, line/data width
TIMEOUT, 64, max cycles in BUSY before abort; 0 disables the watchdog

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
p0_req  input  1  port 0 request; held high, with p0_we/addr/wdata stable, until p0_ack
p0_we  input  1  1 = write, 0 = read
p0_addr  input  ADDR_W  port 0 address
p0_wdata  input  DATA_W  port 0 write data
p0_ack  output  1  one-cycle completion pulse
p0_err  output  1  high with p0_ack when the transaction timed out
p0_rdata  output  DATA_W  read data, valid with p0_ack, held until the next p0_ack
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata  same as port 0, for port 1
ctrl_read  output  1  read request to the controller
ctrl_write  output  1  write request to the controller
ctrl_address  output  ADDR_W  latched address
ctrl_write_data  output  DATA_W  latched write data
ctrl_read_data  input  DATA_W  controller read data, valid when ctrl_done=1
ctrl_done  input  1  controller completion
busy  output  1  high in BUSY and RESP
grant_id  output  1  port owning the current or last transaction

Behaviour:
- Reset values (rst low, asynchronous):
  - state = IDLE; all outputs = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - timeout counter = 0.
- All outputs are registered.
- IDLE:
  - Sample p0_req/p1_req.
  - Only one high: grant it.
  - Both high: grant !last_grant.
  - On grant: latch we/addr/wdata into ctrl_address/ctrl_write_data; set ctrl_read = !we, ctrl_write = we; set grant_id and last_grant to the winner; clear the counter; go to BUSY.
  - Latency: req sampled at edge N; ctrl_read/ctrl_write high in cycle N+1.
- BUSY:
  - Hold ctrl_read/ctrl_write and the latched address/data constant. ctrl_read and ctrl_write are never both high.
  - On ctrl_done = 1 at edge K:
    - Capture ctrl_read_data into the winner's rdata (reads only; writes leave rdata unchanged).
    - Deassert ctrl_read/ctrl_write; winner's ack = 1, err = 0; go to RESP.
  - Otherwise the counter increments each cycle.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT-1 without done:
    - Deassert ctrl_read/ctrl_write; winner's ack = 1, err = 1; rdata unchanged; go to RESP.
  - ctrl_done and timeout in the same cycle: done wins (err = 0).
- RESP:
  - Lasts exactly one cycle with ack high; then IDLE with ack/err = 0.
  - The requester drops req in the cycle after ack. The arbiter re-samples req in IDLE, which gives a mandatory one-cycle gap with ctrl_read/ctrl_write low between transactions.
- Request lifetime:
  - ctrl_done outside BUSY is ignored.
  - Changes to the loser's req, or to the granted port's inputs after the grant, do not affect the in-flight transaction.
  - A requester dropping req mid-transaction does not abort it; ack is still delivered.
- Throughput:
  - Minimum 3 cycles per transaction (IDLE, BUSY, RESP) when ctrl_done arrives in the first BUSY cycle.
  - Under continuous contention, grants strictly alternate.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit. No wrap is possible because of the abort at TIMEOUT-1.
- rst asserted mid-transaction: immediate return to IDLE, all outputs 0, no ack generated.

Test Plan:
- Reset: rst=0 for 3 cycles, then high → all outputs 0, busy=0; p0 read addr 0x0000_1000 → ctrl_read=1 next cycle, ctrl_address=0x0000_1000, p0_ack one cycle after ctrl_done, p0_rdata = ctrl_read_data.
- Contention: p0 and p1 reads held high together for 4 transactions → grant order p0, p1, p0, p1; one idle cycle with ctrl_read=0 between each.
- Write: p1 write addr 0x40, wdata={16{32'hDEADBEEF}} → ctrl_write=1 with that data, ctrl_read=0; p1_ack after done; p1_rdata unchanged from its previous value.
- Timeout: TIMEOUT=8, ctrl_done held 0 → ctrl_read drops after 8 BUSY cycles; p0_ack=1 and p0_err=1 for one cycle; next request is served normally with err=0.
- Edge cases:
  - ctrl_done on the same cycle as the timeout → err=0.
  - ctrl_done pulsed while IDLE → no ack.
- Reset mid-flight: rst=0 for one cycle while BUSY → ctrl_read=0 and busy=0 immediately, no ack; after release, the same pending p0_req is regranted.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: two-port round-robin arbiter in front of a cache controller, with a completion watchdog
module cache_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ctrl_read,
    output logic              ctrl_write,
    output logic [ADDR_W-1:0] ctrl_address,
    output logic [DATA_W-1:0] ctrl_write_data,
    input  logic [DATA_W-1:0] ctrl_read_data,
    input  logic              ctrl_done,
    output logic              busy,
    output logic              grant_id
);
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            r_state;
    logic              r_last, r_gid, r_rd, r_wr, r_busy;
    logic              r_ack0, r_ack1, r_err0, r_err1;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;
    logic              w_any, w_win, w_we, w_to, w_end;

    assign w_any = p0_req || p1_req;
    assign w_win = (p0_req && p1_req) ? !r_last : p1_req;
    assign w_we  = w_win ? p1_we : p0_we;
    assign w_to  = (TIMEOUT != 0) && (r_cnt == LAST);
    assign w_end = ctrl_done || w_to;

    // Grant in IDLE, hold the controller request in BUSY until done or watchdog, pulse ack in RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_gid    <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_busy   <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_gid   <= w_win;
                    r_last  <= w_win;
                    r_addr  <= w_win ? p1_addr : p0_addr;
                    r_wdata <= w_win ? p1_wdata : p0_wdata;
                    r_rd    <= !w_we;
                    r_wr    <= w_we;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= BUSY;
                end
                BUSY: if (w_end) begin
                    if (ctrl_done && r_rd && !r_gid) r_rdata0 <= ctrl_read_data;
                    if (ctrl_done && r_rd && r_gid) r_rdata1 <= ctrl_read_data;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                    r_ack0  <= !r_gid;
                    r_ack1  <= r_gid;
                    r_err0  <= !r_gid && !ctrl_done;
                    r_err1  <= r_gid && !ctrl_done;
                    r_state <= RESP;
                end else if (TIMEOUT != 0) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign p0_ack          = r_ack0;
    assign p0_err          = r_err0;
    assign p0_rdata        = r_rdata0;
    assign p1_ack          = r_ack1;
    assign p1_err          = r_err1;
    assign p1_rdata        = r_rdata1;
    assign ctrl_read       = r_rd;
    assign ctrl_write      = r_wr;
    assign ctrl_address    = r_addr;
    assign ctrl_write_data = r_wdata;
    assign busy            = r_busy;
    assign grant_id        = r_gid;
endmodule
